// File: rtl/io_output_pkg.sv
// Shared constants for the memory-mapped output-port block:
// port word indices, blank control bit and the hex 7-segment table.
package io_output_pkg;

  localparam logic [5:0] IO_OUT0   = 6'h20;
  localparam logic [5:0] IO_OUT1   = 6'h21;
  localparam logic [5:0] IO_OUT2   = 6'h22;
  localparam int         BLANK_BIT = 31;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/io_output_seg7.sv
// 8-digit multiplexed 7-segment scanner: prescaler, digit counter and
// registered anode/cathode drive for a 32-bit hex value.
module io_output_seg7
  import io_output_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [15:0] digits_lo,
  input  logic [15:0] digits_hi,
  input  logic        blank,
  output logic [7:0]  seg_an,
  output logic [6:0]  seg_cat
);

  localparam int             PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_r;
  logic [2:0]    idx_r;
  logic          tick_s;
  logic [31:0]   digits_s;
  logic [3:0]    nib_s;
  logic [7:0]    an_s;
  logic [6:0]    cat_s;
  logic [7:0]    seg_an_r;
  logic [6:0]    seg_cat_r;

  assign tick_s   = (presc_r == PRESC_MAX);
  assign digits_s = {digits_hi, digits_lo};
  assign nib_s    = digits_s[{idx_r, 2'b00} +: 4];

  // Prescaler and digit index; counters run even while blanked
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      presc_r <= {PW{1'b0}};
      idx_r   <= 3'd0;
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
      idx_r   <= idx_r + 3'd1;
    end else begin
      presc_r <= presc_r + PW'(1'b1);
      idx_r   <= idx_r;
    end
  end

  // Drive pattern for the current digit
  always_comb begin
    an_s  = AN_OFF;
    cat_s = SEG_OFF;
    if (blank) begin
      an_s  = AN_OFF;
      cat_s = SEG_OFF;
    end else begin
      an_s  = ~(8'b0000_0001 << idx_r);
      cat_s = seg_lookup(nib_s);
    end
  end

  // Registered display outputs
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      seg_an_r  <= AN_OFF;
      seg_cat_r <= SEG_OFF;
    end else begin
      seg_an_r  <= an_s;
      seg_cat_r <= cat_s;
    end
  end

  assign seg_an  = seg_an_r;
  assign seg_cat = seg_cat_r;

endmodule

// File: rtl/io_output.sv
// Memory-mapped output ports for the single-cycle CPU store path, with
// a built-in hex display of out_port0[15:0] and out_port1[15:0].
module io_output
  import io_output_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic        wr_ack,
  output logic [7:0]  seg_an,
  output logic [6:0]  seg_cat
);

  logic [31:0] port0_r;
  logic [31:0] port1_r;
  logic [31:0] port2_r;
  logic        wr_ack_r;
  logic        sel0_s;
  logic        sel1_s;
  logic        sel2_s;
  logic        accept_s;
  logic        unused_addr_s;

  // Only word-index bits select a port
  assign unused_addr_s = ^{addr[31:8], addr[1:0]};

  // Address decode of the store strobe
  always_comb begin
    sel0_s = 1'b0;
    sel1_s = 1'b0;
    sel2_s = 1'b0;
    if (write_io_enable) begin
      case (addr[7:2])
        IO_OUT0: sel0_s = 1'b1;
        IO_OUT1: sel1_s = 1'b1;
        IO_OUT2: sel2_s = 1'b1;
        default: begin
          sel0_s = 1'b0;
          sel1_s = 1'b0;
          sel2_s = 1'b0;
        end
      endcase
    end else begin
      sel0_s = 1'b0;
      sel1_s = 1'b0;
      sel2_s = 1'b0;
    end
  end

  assign accept_s = sel0_s | sel1_s | sel2_s;

  // Port registers and write acknowledge
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      port0_r  <= 32'h0000_0000;
      port1_r  <= 32'h0000_0000;
      port2_r  <= 32'h0000_0000;
      wr_ack_r <= 1'b0;
    end else begin
      if (sel0_s) port0_r <= datain;
      if (sel1_s) port1_r <= datain;
      if (sel2_s) port2_r <= datain;
      wr_ack_r <= accept_s;
    end
  end

  assign out_port0 = port0_r;
  assign out_port1 = port1_r;
  assign out_port2 = port2_r;
  assign wr_ack    = wr_ack_r;

  io_output_seg7 #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg7 (
    .io_clk    (io_clk),
    .resetn    (resetn),
    .digits_lo (port0_r[15:0]),
    .digits_hi (port1_r[15:0]),
    .blank     (port2_r[BLANK_BIT]),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat)
  );

endmodule

// File: tb/tb_io_output.sv
// Scoreboard bench for io_output: a cycle-level reference model pushes the
// expected outputs per clock; a negedge monitor pops and compares.
module tb_io_output;

  localparam int DIV = 4;

  logic        io_clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] datain = 32'h0;
  logic        write_io_enable = 1'b0;
  logic [31:0] out_port0, out_port1, out_port2;
  logic        wr_ack;
  logic [7:0]  seg_an;
  logic [6:0]  seg_cat;

  always #5 io_clk = ~io_clk;

  io_output #(.SCAN_DIV(DIV)) dut (
    .io_clk(io_clk), .resetn(resetn), .addr(addr), .datain(datain),
    .write_io_enable(write_io_enable), .out_port0(out_port0),
    .out_port1(out_port1), .out_port2(out_port2), .wr_ack(wr_ack),
    .seg_an(seg_an), .seg_cat(seg_cat)
  );

  typedef struct packed {
    logic        ack;
    logic [7:0]  an;
    logic [6:0]  cat;
    logic [95:0] ports;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_port [3] = '{32'h0, 32'h0, 32'h0};
  int unsigned m_cyc = 0;
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digit index follows from the cycle count since reset
  always @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      m_port = '{32'h0, 32'h0, 32'h0};
      m_cyc  = 0;
      exp_q.delete();
    end else begin
      exp_t e;
      int   idx;
      int   w;
      logic [3:0] nib;
      idx = int'((m_cyc / DIV) % 8);
      if (idx < 4) nib = 4'((m_port[0] >> (4 * idx)) & 32'hF);
      else         nib = 4'((m_port[1] >> (4 * (idx - 4))) & 32'hF);
      if (m_port[2][31]) begin
        e.an  = 8'hFF;
        e.cat = 7'h7F;
      end else begin
        e.an  = ~(8'h01 << idx);
        e.cat = hex_tab[nib];
      end
      w = int'(addr[7:2]);
      e.ack = write_io_enable && (w >= 32) && (w <= 34);
      if (e.ack) m_port[w - 32] = datain;
      e.ports = {m_port[0], m_port[1], m_port[2]};
      exp_q.push_back(e);
      m_cyc++;
    end
  end

  // Monitor: outputs are presented every cycle once out of reset
  always @(negedge io_clk) begin
    if (resetn) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_ack",  96'(wr_ack),  96'(e.ack));
        chk("seg_an",  96'(seg_an),  96'(e.an));
        chk("seg_cat", 96'(seg_cat), 96'(e.cat));
        chk("ports",   {out_port0, out_port1, out_port2}, e.ports);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    @(negedge io_clk);
    addr = a;
    datain = d;
    write_io_enable = we;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 1'b0);
  endtask

  // Assert reset in the high phase and check outputs before any edge
  task automatic do_reset();
    @(posedge io_clk);
    #2 resetn = 1'b0;
    write_io_enable = 1'b0;
    #1;
    chk("rst_ports", {out_port0, out_port1, out_port2}, 96'h0);
    chk("rst_ack",   96'(wr_ack),  96'h0);
    chk("rst_an",    96'(seg_an),  96'hFF);
    chk("rst_cat",   96'(seg_cat), 96'h7F);
    repeat (2) @(negedge io_clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] a, d, base;
    repeat (2) @(negedge io_clk);
    #2 resetn = 1'b1;
    idle(40);
    do_reset();
    idle(36);
    drive(32'h0000_0080, 32'h0000_1234, 1'b1);
    idle(40);
    drive(32'h0000_0084, 32'h0000_ABCD, 1'b1);
    drive(32'h0000_0088, 32'h0000_0005, 1'b1);
    idle(40);
    drive(32'h0000_008C, 32'hDEAD_BEEF, 1'b1);
    drive(32'h0000_007C, 32'hCAFE_F00D, 1'b1);
    drive(32'h0000_0080, 32'h5555_5555, 1'b0);
    idle(10);
    drive(32'h0000_0088, 32'h8000_0000, 1'b1);
    idle(12);
    drive(32'h0000_0088, 32'h0000_0000, 1'b1);
    idle(20);
    // Write port0 on the prescaler wrap edge
    for (int k = 0; k < 3; k++) begin
      @(negedge io_clk);
      n = 0;
      while ((m_cyc % DIV) != (DIV - 1) && n < 16) begin
        @(negedge io_clk);
        n++;
      end
      addr = 32'hFFFF_FF83;
      datain = m_port[0] ^ 32'h0000_FFFF;
      write_io_enable = 1'b1;
      idle(DIV * 3);
    end
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: base = 32'h80;
        1: base = 32'h84;
        2: base = 32'h88;
        3: base = 32'h8C;
        4: base = 32'h7C;
        default: base = $urandom;
      endcase
      a = ($urandom & 32'hFFFF_FF03) | (base & 32'h0000_00FC);
      d = $urandom;
      if (a[7:2] == 6'h22 && $urandom_range(0, 3) != 0) d[31] = 1'b0;
      drive(a, d, $urandom_range(0, 3) != 0);
      if (i == 200) do_reset();
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
